// File: rtl/exram_bus_timer_if.sv
// Bridge-side command strobes and external asynchronous SRAM pins of exram_bus_timer.
// slave: the timer; master: the bridge plus external RAM that surround it.
interface exram_bus_timer_if;
  logic        wr_n;
  logic        rd_n;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        busy;
  logic        ovf;
  logic        ext_ce_n;
  logic        ext_we_n;
  logic        ext_oe_n;
  logic [15:0] ext_addr;
  logic [7:0]  ext_dout;
  logic        ext_dout_en;
  logic [7:0]  ext_din;

  modport slave (
    input  wr_n, rd_n, addr, wdata, ext_din,
    output rdata, busy, ovf, ext_ce_n, ext_we_n, ext_oe_n, ext_addr, ext_dout, ext_dout_en
  );

  modport master (
    output wr_n, rd_n, addr, wdata, ext_din,
    input  rdata, busy, ovf, ext_ce_n, ext_we_n, ext_oe_n, ext_addr, ext_dout, ext_dout_en
  );
endinterface

// File: rtl/exram_bus_timer.sv
// Queues one-cycle bridge strobes and plays them out as timed SRAM setup/strobe/hold cycles.
// Define EXRAM_TURNAROUND_EN to insert one idle cycle whenever the access direction changes.
module exram_bus_timer #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  exram_bus_timer_if.slave bus
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int EW   = 1 + 16 + 8;
  localparam int MAXC = (SETUP_CYC > STROBE_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_e;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] head_s, push_ent_s;
  logic          empty_s, full_s, push_s, pop_s, accept_s, ta_block_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    dout_q, dout_d, rdata_q, rdata_d;
  logic          ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic          dout_en_q, dout_en_d, busy_q, busy_d, ovf_q, ovf_d;

  assign empty_s    = (wr_ptr_q == rd_ptr_q);
  assign full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_s     = mem_q[rd_ptr_q[AW-1:0]];
  assign push_s     = !bus.wr_n || !bus.rd_n;
  // A simultaneous read strobe is folded into the write: is_wr wins.
  assign push_ent_s = {!bus.wr_n, bus.addr, bus.wdata};
  assign accept_s   = push_s && (!full_s || pop_s);

`ifdef EXRAM_TURNAROUND_EN
  logic ta_q, ta_d, prev_wr_q, prev_wr_d, have_prev_q, have_prev_d, hold_done_s;

  assign hold_done_s = (state_q == ST_HOLD) && (cnt_q == CNT_ZERO);
  assign ta_block_s  = have_prev_q && !ta_q && (head_s[EW-1] != prev_wr_q);

  // Turnaround bookkeeping: direction of the last completed access and the one-cycle stall flag.
  always_comb begin
    ta_d        = (state_q == ST_IDLE) && !empty_s && ta_block_s;
    prev_wr_d   = hold_done_s ? is_wr_q : prev_wr_q;
    have_prev_d = have_prev_q || hold_done_s;
  end

  // Turnaround state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ta_q        <= 1'b0;
      prev_wr_q   <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      ta_q        <= ta_d;
      prev_wr_q   <= prev_wr_d;
      have_prev_q <= have_prev_d;
    end
  end
`else
  assign ta_block_s = 1'b0;
`endif

  // Command storage; entries need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_ent_s;
    end
  end

  // Phase sequencer: pop in IDLE, then count down through SETUP, STROBE and HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s && !ta_block_s) begin
          pop_s   = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          is_wr_d = head_s[EW-1];
          addr_d  = head_s[23:8];
          dout_d  = head_s[7:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_STROBE;
          cnt_d   = CW'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
          rdata_d = is_wr_q ? rdata_q : bus.ext_din;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Pin values are decoded from the next state so every ext_* output leaves a flop.
  always_comb begin
    ce_n_d    = (state_d == ST_IDLE);
    we_n_d    = !((state_d == ST_STROBE) && is_wr_d);
    oe_n_d    = !((state_d == ST_STROBE) && !is_wr_d);
    dout_en_d = (state_d != ST_IDLE) && is_wr_d;
    wr_ptr_d  = accept_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    busy_d    = (state_d != ST_IDLE) || (wr_ptr_d != rd_ptr_d);
    ovf_d     = ovf_q || (push_s && !accept_s);
  end

  // State, FIFO pointers and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      is_wr_q   <= 1'b0;
      addr_q    <= 16'h0000;
      dout_q    <= 8'h00;
      rdata_q   <= 8'h00;
      wr_ptr_q  <= {(AW+1){1'b0}};
      rd_ptr_q  <= {(AW+1){1'b0}};
      ce_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      dout_en_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      rdata_q   <= rdata_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ce_n_q    <= ce_n_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      dout_en_q <= dout_en_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.ext_ce_n    = ce_n_q;
  assign bus.ext_we_n    = we_n_q;
  assign bus.ext_oe_n    = oe_n_q;
  assign bus.ext_addr    = addr_q;
  assign bus.ext_dout    = dout_q;
  assign bus.ext_dout_en = dout_en_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_exram_bus_timer.sv
// Scoreboard bench for exram_bus_timer: commands queue expected accesses, a bus monitor
// reconstructs each external access and compares it against the queue head.
module tb_exram_bus_timer;
  typedef struct packed {
    logic        is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic clk;
  logic rst;
  exram_bus_timer_if bus ();

  exram_bus_timer dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t        exp_q [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          acc_count = 0;
  int          last_gap = 0;
  logic [7:0]  exp_rdata = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM model: drives a known pattern only while output enable is active.
  function automatic logic [7:0] ram_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction

  assign bus.ext_din = bus.ext_oe_n ? 8'hEE : ram_f(bus.ext_addr);

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input bit w, input bit r, input logic [15:0] a, input logic [7:0] d);
    bus.wr_n  = !w;
    bus.rd_n  = !r;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wr_n  = 1'b1;
    bus.rd_n  = 1'b1;
  endtask

  task automatic push_exp(input bit w, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.is_wr = w;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk_eq("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Bus monitor: rebuilds each ce_n-low window and scores it against the expected queue.
  initial begin
    bit          in_acc;
    int          idx;
    int          gap;
    logic [7:0]  we_m, oe_m, en_m, rd_seen, d0;
    logic [15:0] a0;
    bit          stable;
    exp_t        e;
    in_acc = 1'b0; idx = 0; gap = 0;
    we_m = 8'h00; oe_m = 8'h00; en_m = 8'h00; rd_seen = 8'h00; d0 = 8'h00; a0 = 16'h0000;
    stable = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_acc = 1'b0;
        gap    = 0;
      end else if (!bus.ext_ce_n) begin
        if (!in_acc) begin
          in_acc = 1'b1; idx = 0; last_gap = gap; gap = 0;
          we_m = 8'h00; oe_m = 8'h00; en_m = 8'h00; stable = 1'b1;
          a0 = bus.ext_addr; d0 = bus.ext_dout;
        end
        if (idx < 8) begin
          we_m[idx] = !bus.ext_we_n;
          oe_m[idx] = !bus.ext_oe_n;
          en_m[idx] = bus.ext_dout_en;
        end
        if (bus.ext_addr !== a0 || bus.ext_dout !== d0) stable = 1'b0;
        if (idx == 3) rd_seen = bus.rdata;
        idx++;
      end else begin
        gap++;
        if (in_acc) begin
          in_acc = 1'b0;
          acc_count++;
          if (exp_q.size() == 0) begin
            chk_eq("unexpected_access", {16'h0000, a0}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk_eq("acc_len", idx, 32'd4);
            chk_eq("acc_addr", a0, e.addr);
            chk_eq("acc_we_mask", we_m, e.is_wr ? 8'h06 : 8'h00);
            chk_eq("acc_oe_mask", oe_m, e.is_wr ? 8'h00 : 8'h06);
            chk_eq("acc_douten_mask", en_m, e.is_wr ? 8'h0F : 8'h00);
            chk_eq("acc_stable", stable, 1'b1);
            if (e.is_wr) chk_eq("acc_wdata", d0, e.data);
            else exp_rdata = ram_f(e.addr);
            chk_eq("acc_rdata", rd_seen, exp_rdata);
          end
        end
      end
    end
  end

  initial begin
    int acc_snap;
    rst = 1'b1;
    bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.addr = 16'h0000; bus.wdata = 8'h00;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk_eq("rst_ce_n", bus.ext_ce_n, 1'b1);
    chk_eq("rst_we_n", bus.ext_we_n, 1'b1);
    chk_eq("rst_oe_n", bus.ext_oe_n, 1'b1);
    chk_eq("rst_addr", bus.ext_addr, 16'h0000);
    chk_eq("rst_dout", bus.ext_dout, 8'h00);
    chk_eq("rst_douten", bus.ext_dout_en, 1'b0);
    chk_eq("rst_rdata", bus.rdata, 8'h00);
    chk_eq("rst_busy", bus.busy, 1'b0);
    chk_eq("rst_ovf", bus.ovf, 1'b0);

    // Single write with pop-cycle and busy timing.
    push_exp(1'b1, 16'h1234, 8'hA5);
    cmd(1'b1, 1'b0, 16'h1234, 8'hA5);
    chk_eq("wr_pop_cycle_ce_n", bus.ext_ce_n, 1'b1);
    chk_eq("wr_pop_cycle_busy", bus.busy, 1'b1);
    @(negedge clk);
    chk_eq("wr_setup_ce_n", bus.ext_ce_n, 1'b0);
    chk_eq("wr_setup_we_n", bus.ext_we_n, 1'b1);
    repeat (4) @(negedge clk);
    chk_eq("wr_after_hold_ce_n", bus.ext_ce_n, 1'b1);
    chk_eq("wr_after_hold_busy", bus.busy, 1'b0);
    wait_idle();

    // Single read, then held rdata.
    push_exp(1'b0, 16'h00FF, 8'h00);
    cmd(1'b0, 1'b1, 16'h00FF, 8'h00);
    wait_idle();
    chk_eq("rd_rdata_held", bus.rdata, 8'h3C);

    // Simultaneous strobes become one write; rdata untouched.
    push_exp(1'b1, 16'h0010, 8'h77);
    cmd(1'b1, 1'b1, 16'h0010, 8'h77);
    wait_idle();
    chk_eq("simul_rdata", bus.rdata, 8'h3C);
    chk_eq("simul_ovf", bus.ovf, 1'b0);

    // Back-to-back write then read: gap before the read setup.
    push_exp(1'b1, 16'h2000, 8'h5A);
    push_exp(1'b0, 16'h2001, 8'h00);
    cmd(1'b1, 1'b0, 16'h2000, 8'h5A);
    cmd(1'b0, 1'b1, 16'h2001, 8'h00);
    wait_idle();
`ifdef EXRAM_TURNAROUND_EN
    chk_eq("wr_rd_gap", last_gap, 32'd2);
`else
    chk_eq("wr_rd_gap", last_gap, 32'd1);
`endif

    // Overflow: six writes, the sixth lands while full with no pop.
    for (int i = 0; i < 6; i++) begin
      if (i < 5) push_exp(1'b1, 16'(i), 8'(8'h10 + i));
      cmd(1'b1, 1'b0, 16'(i), 8'(8'h10 + i));
    end
    chk_eq("ovf_set", bus.ovf, 1'b1);
    wait_idle();
    chk_eq("ovf_sticky", bus.ovf, 1'b1);
    chk_eq("ovf_queue_drained", exp_q.size(), 32'd0);

    // Reset during the strobe of a write with two commands still queued.
    push_exp(1'b1, 16'h3000, 8'hC1);
    cmd(1'b1, 1'b0, 16'h3000, 8'hC1);
    cmd(1'b1, 1'b0, 16'h3001, 8'hC2);
    cmd(1'b0, 1'b1, 16'h3002, 8'h00);
    chk_eq("pre_rst_we_n", bus.ext_we_n, 1'b0);
    #2 rst = 1'b1;
    exp_q.delete();
    exp_rdata = 8'h00;
    #1;
    chk_eq("async_rst_we_n", bus.ext_we_n, 1'b1);
    chk_eq("async_rst_ce_n", bus.ext_ce_n, 1'b1);
    chk_eq("async_rst_busy", bus.busy, 1'b0);
    chk_eq("async_rst_ovf", bus.ovf, 1'b0);
    chk_eq("async_rst_rdata", bus.rdata, 8'h00);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    acc_snap = acc_count;
    repeat (20) @(negedge clk);
    chk_eq("post_rst_no_access", acc_count, acc_snap);
    chk_eq("post_rst_busy", bus.busy, 1'b0);
    chk_eq("post_rst_ce_n", bus.ext_ce_n, 1'b1);

    chk_eq("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
